// File: rtl/lp_xfer_ctrl_pkg.sv
// Shared types and defaults for the LP20 transfer sequencer.
// The optional demand timer is enabled by defining LP20_DTE_EN.
package lp_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SENDLO,
    ST_SENDHI,
    ST_FINISH
  } state_t;

  localparam int DTE_CYCLES_DEF = 1000000;
  localparam int BCTR_WIDTH_DEF = 12;

  function automatic int dte_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/lp_xfer_ctrl_if.sv
// DMA word-fetch and printer character handshake bundle for the LP20 sequencer.
interface lp_xfer_ctrl_if;
  logic        dmaREQ;
  logic        dmaACK;
  logic        dmaNXM;
  logic [15:0] dmaDATA;
  logic        lpDEMAND;
  logic        lpSTROBE;
  logic [7:0]  lpDATA;

  modport master (
    output dmaREQ,
    input  dmaACK,
    input  dmaNXM,
    input  dmaDATA,
    input  lpDEMAND,
    output lpSTROBE,
    output lpDATA
  );

  modport slave (
    input  dmaREQ,
    output dmaACK,
    output dmaNXM,
    output dmaDATA,
    output lpDEMAND,
    input  lpSTROBE,
    input  lpDATA
  );
endinterface

// File: rtl/lp_xfer_ctrl_dte_timer.sv
// Printer demand timeout counter; present only when LP20_DTE_EN is defined.
`ifdef LP20_DTE_EN
module lp_dte_timer
  import lp_xfer_pkg::*;
#(
  parameter int DTE_CYCLES = DTE_CYCLES_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = dte_w(DTE_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (run && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = run && !clear && (cnt == W'(DTE_CYCLES - 1));

endmodule
`endif

// File: rtl/lp_xfer_ctrl.sv
// LP20 DMA print sequencer: fetches words, unpacks low byte first, strobes bytes on demand.
// Define LP20_DTE_EN to include the printer demand timeout (lpDTE); otherwise lpDTE is 0.
module lp_xfer_ctrl
  import lp_xfer_pkg::*;
#(
  parameter int DTE_CYCLES = DTE_CYCLES_DEF,
  parameter int BCTR_WIDTH = BCTR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lpINIT,
  input  logic                  lpCMDGO,
  input  logic                  lpERR,
  input  logic [BCTR_WIDTH-1:0] lpBCTR,
  lp_xfer_ctrl_if.master        bus,
  output logic                  lpGO,
  output logic                  lpDONE,
  output logic                  lpGOE,
  output logic                  lpDTE,
  output logic                  lpMTE,
  output logic [BCTR_WIDTH-1:0] lpCOUNT
);

  state_t      state;
  logic [15:0] word;
  logic        armed;
  logic        in_send;
  logic        fire;
  logic        dte_exp;

  assign in_send = (state == ST_SENDLO) || (state == ST_SENDHI);

  // A byte goes out only once demand has been seen low since the previous strobe.
  assign fire = in_send && !bus.lpSTROBE && bus.lpDEMAND && armed && !lpERR;

`ifdef LP20_DTE_EN
  lp_dte_timer #(
    .DTE_CYCLES(DTE_CYCLES)
  ) u_dte (
    .clk   (clk),
    .clear (!in_send || bus.lpSTROBE || fire),
    .run   (in_send),
    .expire(dte_exp)
  );
`else
  logic unused_dte_cfg;
  assign unused_dte_cfg = (DTE_CYCLES > 0);
  assign dte_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || lpINIT) begin
      state        <= ST_IDLE;
      lpGO         <= 1'b0;
      lpDONE       <= 1'b1;
      bus.dmaREQ   <= 1'b0;
      bus.lpSTROBE <= 1'b0;
      bus.lpDATA   <= '0;
      lpGOE        <= 1'b0;
      lpDTE        <= 1'b0;
      lpMTE        <= 1'b0;
      armed        <= 1'b1;
      if (rst) begin
        lpCOUNT <= '0;
      end
    end else begin
      bus.lpSTROBE <= 1'b0;
      lpGOE        <= lpCMDGO && lpGO;
      lpDTE        <= 1'b0;
      lpMTE        <= 1'b0;
      if (!bus.lpDEMAND) begin
        armed <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (lpCMDGO && (lpBCTR != '0)) begin
            lpCOUNT    <= lpBCTR;
            lpGO       <= 1'b1;
            lpDONE     <= 1'b0;
            bus.dmaREQ <= 1'b1;
            armed      <= 1'b1;
            state      <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (lpERR) begin
            bus.dmaREQ <= 1'b0;
            state      <= ST_FINISH;
          end else if (bus.dmaNXM) begin
            bus.dmaREQ <= 1'b0;
            lpMTE      <= 1'b1;
            state      <= ST_FINISH;
          end else if (bus.dmaACK) begin
            bus.dmaREQ <= 1'b0;
            word       <= bus.dmaDATA;
            state      <= ST_SENDLO;
          end
        end

        ST_SENDLO, ST_SENDHI: begin
          if (lpERR) begin
            state <= ST_FINISH;
          end else if (bus.lpSTROBE) begin
            // Cycle after a strobe: the decremented count decides where to go.
            if (lpCOUNT == '0) begin
              state <= ST_FINISH;
            end else if (state == ST_SENDLO) begin
              state <= ST_SENDHI;
            end else begin
              bus.dmaREQ <= 1'b1;
              state      <= ST_FETCH;
            end
          end else if (fire) begin
            bus.lpSTROBE <= 1'b1;
            bus.lpDATA   <= (state == ST_SENDLO) ? word[7:0] : word[15:8];
            lpCOUNT      <= lpCOUNT - 1'b1;
            armed        <= 1'b0;
          end else if (dte_exp) begin
            lpDTE <= 1'b1;
            state <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          lpGO   <= 1'b0;
          lpDONE <= 1'b1;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lp_xfer_ctrl.sv
// Self-checking bench for lp_xfer_ctrl with DMA responder, printer model and byte-stream reference.
module tb_lp_xfer_ctrl;

  localparam int BW  = 12;
  localparam int DTE = 16;

  logic          clk = 1'b0;
  logic          rst, lpINIT, lpCMDGO, lpERR;
  logic [BW-1:0] lpBCTR;
  logic          lpGO, lpDONE, lpGOE, lpDTE, lpMTE;
  logic [BW-1:0] lpCOUNT;

  lp_xfer_ctrl_if bus();

  lp_xfer_ctrl #(.DTE_CYCLES(DTE), .BCTR_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .lpINIT(lpINIT), .lpCMDGO(lpCMDGO), .lpERR(lpERR),
    .lpBCTR(lpBCTR), .bus(bus), .lpGO(lpGO), .lpDONE(lpDONE), .lpGOE(lpGOE),
    .lpDTE(lpDTE), .lpMTE(lpMTE), .lpCOUNT(lpCOUNT)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory image served by the DMA responder, and its behaviour knobs.
  logic [15:0] mem [8];
  int          widx;
  int          dly;
  bit          nxm_mode;
  int          pmode;
  int          busy;

  // Observed activity, gathered one delta after each rising edge.
  logic [7:0]    got_b[$];
  logic [BW-1:0] got_c[$];
  int cyc, last_strobe_cyc, done_rise_cyc, ack_cyc, dte_cyc;
  int req_rises, goe_n, mte_n, dte_n, ack_n;
  bit req_q, done_q, sack;

  initial begin
    bus.dmaACK = 0; bus.dmaNXM = 0; bus.dmaDATA = '0; dly = 0;
    forever begin
      @(negedge clk);
      bus.dmaACK = 0;
      bus.dmaNXM = 0;
      if (bus.dmaREQ === 1'b1) begin
        if (dly > 0) dly--;
        else begin
          if (nxm_mode) bus.dmaNXM = 1;
          else begin
            bus.dmaACK  = 1;
            bus.dmaDATA = mem[widx % 8];
            widx++;
          end
          dly = $urandom_range(0, 3);
        end
      end
    end
  end

  // Printer: ready by default, goes busy for a few cycles after each character.
  initial begin
    bus.lpDEMAND = 0; busy = 0;
    forever begin
      @(negedge clk);
      if (pmode == 0) begin
        if (bus.lpSTROBE === 1'b1) busy = $urandom_range(1, 3);
        if (busy > 0) begin bus.lpDEMAND = 0; busy--; end
        else bus.lpDEMAND = 1;
      end else if (pmode == 1) begin
        bus.lpDEMAND = 0;
      end
    end
  end

  initial begin
    cyc = 0; req_q = 0; done_q = 1;
    forever begin
      @(posedge clk);
      cyc++;
      sack = bus.dmaACK;
      #1;
      if (bus.lpSTROBE === 1'b1) begin
        got_b.push_back(bus.lpDATA);
        got_c.push_back(lpCOUNT);
        last_strobe_cyc = cyc;
      end
      if (bus.dmaREQ === 1'b1 && !req_q) req_rises++;
      req_q = (bus.dmaREQ === 1'b1);
      if (lpDONE === 1'b1 && !done_q) done_rise_cyc = cyc;
      done_q = (lpDONE === 1'b1);
      if (lpGOE === 1'b1) goe_n++;
      if (lpMTE === 1'b1) mte_n++;
      if (lpDTE === 1'b1) begin dte_n++; dte_cyc = cyc; end
      if (sack) begin ack_n++; ack_cyc = cyc; end
    end
  end

  task automatic clr_stats();
    got_b.delete(); got_c.delete();
    req_rises = 0; goe_n = 0; mte_n = 0; dte_n = 0; ack_n = 0;
    last_strobe_cyc = 0; done_rise_cyc = 0; ack_cyc = 0; dte_cyc = 0;
    widx = 0;
  endtask

  task automatic go(input int n);
    @(negedge clk);
    lpCMDGO = 1; lpBCTR = BW'(n);
    @(negedge clk);
    lpCMDGO = 0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (lpDONE !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    chk($sformatf("%s_done_in_time", tag), (k < 3000), 1'b1);
  endtask

  // Reference: bytes leave low byte first, count runs down to zero, one fetch per word.
  task automatic xfer_check(input string tag, input int n);
    logic [7:0] eb;
    chk($sformatf("%s_nbytes", tag), got_b.size(), n);
    for (int i = 0; i < n && i < got_b.size(); i++) begin
      eb = (i % 2 == 0) ? mem[i / 2][7:0] : mem[i / 2][15:8];
      chk($sformatf("%s_byte%0d", tag, i), got_b[i], eb);
      chk($sformatf("%s_cnt%0d", tag, i), got_c[i], BW'(n - 1 - i));
    end
    chk($sformatf("%s_reqs", tag), req_rises, (n + 1) / 2);
    chk($sformatf("%s_done_latency", tag), done_rise_cyc - last_strobe_cyc, 2);
    chk($sformatf("%s_go_low", tag), lpGO, 1'b0);
    chk($sformatf("%s_count_end", tag), lpCOUNT, BW'(0));
  endtask

  initial begin
    int n, k;
    rst = 1; lpINIT = 0; lpCMDGO = 0; lpERR = 0; lpBCTR = '0;
    pmode = 0; nxm_mode = 0;
    clr_stats();
    repeat (3) @(negedge clk);
    chk("rst_done", lpDONE, 1'b1);
    chk("rst_go", lpGO, 1'b0);
    chk("rst_req", bus.dmaREQ, 1'b0);
    chk("rst_strobe", bus.lpSTROBE, 1'b0);
    chk("rst_data", bus.lpDATA, 8'h00);
    chk("rst_count", lpCOUNT, BW'(0));
    chk("rst_errs", {lpGOE, lpDTE, lpMTE}, 3'b000);
    rst = 0;

    // Three bytes from two words; high byte of the second word discarded.
    mem[0] = 16'h4241; mem[1] = 16'h0043;
    clr_stats();
    go(3);
    chk("t1_go_high", lpGO, 1'b1);
    chk("t1_count_load", lpCOUNT, BW'(3));
    wait_done("t1");
    xfer_check("t1", 3);

    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 9);
      for (int j = 0; j < 8; j++) mem[j] = 16'($urandom);
      clr_stats();
      go(n);
      wait_done($sformatf("rnd%0d", t));
      xfer_check($sformatf("rnd%0d", t), n);
    end

    // Zero byte count: the command is a no-op.
    clr_stats();
    go(0);
    repeat (8) @(negedge clk);
    chk("t2_reqs", req_rises, 0);
    chk("t2_strobes", got_b.size(), 0);
    chk("t2_go", lpGO, 1'b0);
    chk("t2_done", lpDONE, 1'b1);

    // Go while busy: error pulse only.
    for (int j = 0; j < 8; j++) mem[j] = 16'($urandom);
    clr_stats();
    dly = 8;
    go(4);
    chk("t3_req", bus.dmaREQ, 1'b1);
    go(7);
    chk("t3_count_kept", lpCOUNT, BW'(4));
    wait_done("t3");
    chk("t3_goe_pulses", goe_n, 1);
    xfer_check("t3", 4);

    // Bus timeout on the first fetch.
    clr_stats();
    nxm_mode = 1;
    go(5);
    wait_done("t4");
    nxm_mode = 0;
    chk("t4_mte", mte_n, 1);
    chk("t4_strobes", got_b.size(), 0);
    chk("t4_count", lpCOUNT, BW'(5));
    chk("t4_go", lpGO, 1'b0);

    // Error together with demand: error wins, no strobe.
    clr_stats();
    pmode = 2; bus.lpDEMAND = 0;
    go(4);
    k = 0;
    while (ack_n == 0 && k < 50) begin @(negedge clk); k++; end
    chk("terr_ack_seen", (k < 50), 1'b1);
    @(negedge clk);
    bus.lpDEMAND = 1; lpERR = 1;
    @(negedge clk);
    lpERR = 0; bus.lpDEMAND = 0;
    repeat (3) @(negedge clk);
    chk("terr_strobes", got_b.size(), 0);
    chk("terr_done", lpDONE, 1'b1);
    chk("terr_go", lpGO, 1'b0);
    chk("terr_count", lpCOUNT, BW'(4));

    // Printer never ready.
    clr_stats();
    pmode = 1;
    go(2);
`ifdef LP20_DTE_EN
    wait_done("t5");
    chk("t5_dte", dte_n, 1);
    chk("t5_dte_delay", dte_cyc - ack_cyc, DTE);
    chk("t5_strobes", got_b.size(), 0);
    chk("t5_count", lpCOUNT, BW'(2));
`else
    repeat (60) @(negedge clk);
    chk("t5_no_dte", dte_n, 0);
    chk("t5_still_go", lpGO, 1'b1);
    chk("t5_strobes", got_b.size(), 0);
    @(negedge clk); lpERR = 1;
    @(negedge clk); lpERR = 0;
    repeat (2) @(negedge clk);
    chk("t5_abort_done", lpDONE, 1'b1);
`endif

    // Init in the same cycle as demand in the high-byte state.
    for (int j = 0; j < 8; j++) mem[j] = 16'($urandom);
    clr_stats();
    pmode = 2; bus.lpDEMAND = 1;
    go(4);
    k = 0;
    while (got_b.size() == 0 && k < 50) begin @(negedge clk); k++; end
    chk("t6_first_strobe", got_b.size(), 1);
    bus.lpDEMAND = 0;
    repeat (2) @(negedge clk);
    bus.lpDEMAND = 1; lpINIT = 1;
    @(negedge clk);
    lpINIT = 0; bus.lpDEMAND = 0;
    chk("t6_no_strobe", got_b.size(), 1);
    chk("t6_go", lpGO, 1'b0);
    chk("t6_done", lpDONE, 1'b1);
    chk("t6_count_kept", lpCOUNT, BW'(3));
    chk("t6_req", bus.dmaREQ, 1'b0);

    // Normal operation after init.
    pmode = 0;
    n = $urandom_range(1, 9);
    for (int j = 0; j < 8; j++) mem[j] = 16'($urandom);
    repeat (4) @(negedge clk);
    clr_stats();
    go(n);
    wait_done("t7");
    xfer_check("t7", n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lp_xfer_ctrl.md
Name: lp_xfer_ctrl

Overview:
- Transfer sequencer for the LP20 printer datapath.
- Started by the CSRA Go command; runs a byte-count-limited DMA print operation.
- Fetches 16-bit words over the Unibus DMA handshake, unpacks them low byte first, and strobes each byte to the printer on demand.
- Drives the CSRA status inputs GO, DONE, GOE, DTE and MTE; honours INIT and ERR from CSRA.

Parameters:
- DTE_CYCLES, 1000000: clock cycles allowed between printer demand and strobe before a demand-timeout error.
- BCTR_WIDTH, 12: width of the byte counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lpINIT  in  1  CSRA initialize (devRESET or INIT write)
- lpCMDGO  in  1  CSRA Go command, 1-cycle pulse
- lpERR  in  1  CSRA error flag; aborts transfer
- lpBCTR  in  BCTR_WIDTH  byte count, sampled on accepted Go
- dmaREQ  out  1  Unibus DMA read request
- dmaACK  in  1  DMA data valid, 1-cycle pulse
- dmaNXM  in  1  DMA Unibus timeout, 1-cycle pulse
- dmaDATA  in  16  DMA read word
- lpDEMAND  in  1  printer ready for a character
- lpSTROBE  out  1  character valid, 1-cycle pulse
- lpDATA  out  8  character to printer
- lpGO  out  1  transfer active
- lpDONE  out  1  controller idle/complete
- lpGOE  out  1  Go-while-busy error, 1-cycle pulse
- lpDTE  out  1  demand timeout, 1-cycle pulse
- lpMTE  out  1  memory timeout, 1-cycle pulse
- lpCOUNT  out  BCTR_WIDTH  remaining byte count

Behaviour:
- Reset values: state IDLE, lpGO=0, lpDONE=1, dmaREQ=0, lpSTROBE=0, lpDATA=0, lpCOUNT=0, all error pulses 0.
- lpINIT has the same effect as rst, except that lpCOUNT is preserved.
- lpINIT takes priority over every other event in the same cycle.
- **IDLE**
  - lpCMDGO with lpBCTR≠0: lpCOUNT←lpBCTR, lpGO←1, lpDONE←0, go to FETCH.
  - lpCMDGO with lpBCTR=0: stay in IDLE; lpDONE remains 1; lpGO stays 0.
- **FETCH**
  - dmaREQ=1 is held until dmaACK or dmaNXM.
  - dmaACK: latch dmaDATA, drop dmaREQ in the same cycle, go to SENDLO.
  - dmaNXM: lpMTE pulses, go to FINISH.
- **SENDLO / SENDHI**
  - Wait for lpDEMAND=1, then emit one lpSTROBE pulse with lpDATA = word[7:0] (SENDLO) or word[15:8] (SENDHI); lpCOUNT decrements in the same cycle.
  - After a strobe, a further strobe requires lpDEMAND to be seen low and then high again.
  - If lpCOUNT reaches 0 after the strobe: go to FINISH.
  - Otherwise SENDLO goes to SENDHI, and SENDHI goes to FETCH.
  - An odd count ends after SENDLO; the high byte is discarded.
- **FINISH**
  - One cycle: lpGO←0, lpDONE←1, then IDLE.
  - Latency from the last strobe to lpDONE=1 is 2 cycles.
- lpCMDGO while lpGO=1: lpGOE pulses for 1 cycle; the command is otherwise ignored.
- lpERR=1 in FETCH, SENDLO or SENDHI: go to FINISH next cycle.
  - dmaREQ drops immediately.
  - A strobe in that same cycle is suppressed.
- Demand timer:
  - Cleared on every strobe and on entry to SENDLO/SENDHI.
  - Counts while in SENDLO/SENDHI and no strobe occurs.
  - On reaching DTE_CYCLES-1: lpDTE pulses, go to FINISH.
- Simultaneous events: lpERR and lpDEMAND in the same cycle, ERR wins. dmaACK and dmaNXM together, NXM wins.

Optional Feature:
- Macro LP20_DTE_EN.
- Defined: demand timer is present as described above.
- Undefined: no timer logic; lpDTE is tied 0 and the SEND states wait indefinitely for lpDEMAND.

Decomposition:
- Package lp_xfer_pkg holds:
  - state encoding (IDLE, FETCH, SENDLO, SENDHI, FINISH);
  - the DTE_CYCLES default;
  - the BCTR_WIDTH default;
  - the timer width function (clog2 of DTE_CYCLES).
- One sub-module: lp_dte_timer, with clear, run and expire ports, compiled only under LP20_DTE_EN.

Test Plan:
1. Go, lpBCTR=3, words 0x4241 and 0x0043, demand always high → strobes 0x41, 0x42, 0x43; one dmaREQ per word; lpCOUNT 3→0; lpDONE=1 two cycles after the last strobe.
2. Go with lpBCTR=0 → no dmaREQ, no strobe, lpGO stays 0, lpDONE stays 1.
3. Second lpCMDGO during FETCH → lpGOE is a single 1-cycle pulse; lpCOUNT unchanged; transfer completes normally.
4. dmaNXM in place of the first ACK, lpBCTR=5 → lpMTE pulse, no strobe, lpDONE=1, lpCOUNT=5.
5. With LP20_DTE_EN and DTE_CYCLES=16, demand held low in SENDLO → lpDTE pulse after 16 cycles, then FINISH.
6. lpINIT in the same cycle as lpDEMAND during SENDHI → no strobe; next cycle IDLE, lpGO=0, lpDONE=1.
